// File: rtl/bcd_serial_alu.sv
// rtl/bcd_serial_alu.sv - digit-serial packed-BCD add/subtract unit
//
// Purpose: adds or subtracts two DIGITS-digit packed-BCD operands using one
// single-digit BCD slice, least-significant digit first, one digit per clock.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_start, o_ready     request handshake; operands accepted when ready
//   i_sub                0 = a+b, 1 = a-b (sampled with start)
//   i_a, i_b             packed BCD operands, digit 0 in bits [3:0]
//   o_busy               computation in progress
//   o_valid, i_ack       result handshake; result held until ack
//   o_result, o_cout     packed BCD result and final digit carry
//   o_err                an input digit was above 9 (result/cout forced 0)
module bcd_serial_alu #(
    parameter int DIGITS = 4,
    parameter int CW     = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_sub,
    input  logic [4*DIGITS-1:0]   i_a,
    input  logic [4*DIGITS-1:0]   i_b,
    output logic                  o_ready,
    output logic                  o_busy,
    output logic                  o_valid,
    input  logic                  i_ack,
    output logic [4*DIGITS-1:0]   o_result,
    output logic                  o_cout,
    output logic                  o_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [4*DIGITS-1:0]   r_opa;
    logic [4*DIGITS-1:0]   r_opb;
    logic [4*DIGITS-1:0]   r_result;
    logic                  r_sub;
    logic                  r_carry;
    logic                  r_cout;
    logic                  r_err;
    logic [CW-1:0]         r_cnt;

    logic                  w_last;
    logic                  w_in_err;
    logic [3:0]            w_bdig;
    logic [4:0]            w_z;
    logic                  w_dcarry;
    logic [3:0]            w_digit;
    logic [4*DIGITS-1:0]   w_result_next;

    assign w_last = (r_cnt == CW'(DIGITS - 1));

    // Any operand digit outside 0..9 flags the whole operation as invalid.
    always_comb begin
        w_in_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (i_a[4*i +: 4] > 4'd9 || i_b[4*i +: 4] > 4'd9) begin
                w_in_err = 1'b1;
            end
        end
    end

    // Single-digit slice: subtract adds the nine's complement of b, with the
    // initial carry preset to 1 so the chain forms the ten's complement.
    assign w_bdig   = r_sub ? (4'd9 - r_opb[3:0]) : r_opb[3:0];
    assign w_z      = {1'b0, r_opa[3:0]} + {1'b0, w_bdig} + {4'b0000, r_carry};
    assign w_dcarry = (w_z > 5'd9);
    assign w_digit  = w_dcarry ? (w_z[3:0] + 4'd6) : w_z[3:0];

    // New digit enters at the top so that after DIGITS shifts digit 0 sits
    // in bits [3:0].
    generate
        if (DIGITS == 1) begin : g_one_digit
            assign w_result_next = w_digit;
        end else begin : g_multi_digit
            assign w_result_next = {w_digit, r_result[4*DIGITS-1:4]};
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        o_ready = 1'b0;
        o_busy  = 1'b0;
        o_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_start) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                o_busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                o_valid = 1'b1;
                if (i_ack) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_opa    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_sub    <= 1'b0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_opa   <= i_a;
                        r_opb   <= i_b;
                        r_sub   <= i_sub;
                        r_carry <= i_sub;
                        r_cnt   <= '0;
                        r_err   <= w_in_err;
                    end
                end
                S_RUN: begin
                    r_result <= w_result_next;
                    r_opa    <= r_opa >> 4;
                    r_opb    <= r_opb >> 4;
                    r_carry  <= w_dcarry;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_cout <= r_err ? 1'b0 : w_dcarry;
                        if (r_err) begin
                            r_result <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_result = r_result;
    assign o_cout   = r_cout;
    assign o_err    = r_err;

endmodule

// File: tb/tb_bcd_serial_alu.sv
// tb/tb_bcd_serial_alu.sv - self-checking bench for bcd_serial_alu
module tb_bcd_serial_alu;

    localparam int DIGITS = 2;
    localparam int CW     = 2;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         valid;
    logic         ack;
    logic [W-1:0] result;
    logic         cout;
    logic         err;

    always #5 clk = ~clk;

    bcd_serial_alu #(
        .DIGITS (DIGITS),
        .CW     (CW)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_sub    (sub),
        .i_a      (a),
        .i_b      (b),
        .o_ready  (ready),
        .o_busy   (busy),
        .o_valid  (valid),
        .i_ack    (ack),
        .o_result (result),
        .o_cout   (cout),
        .o_err    (err)
    );

    typedef struct packed {
        logic [W-1:0] result;
        logic         cout;
        logic         err;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model in plain integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub);
        int   ai;
        int   bi;
        int   s;
        int   m;
        bit   bad;
        exp_t e;
        ai  = 0;
        bi  = 0;
        m   = 1;
        bad = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (ma[4*i +: 4] > 4'd9 || mb[4*i +: 4] > 4'd9) bad = 1'b1;
            ai = ai * 10 + int'(ma[4*i +: 4]);
            bi = bi * 10 + int'(mb[4*i +: 4]);
            m  = m * 10;
        end
        s        = msub ? (ai + (m - 1 - bi) + 1) : (ai + bi);
        e.cout   = (s >= m);
        s        = s % m;
        e.result = '0;
        for (int i = 0; i < DIGITS; i++) begin
            e.result[4*i +: 4] = 4'(s % 10);
            s = s / 10;
        end
        e.err = bad;
        if (bad) begin
            e.result = '0;
            e.cout   = 1'b0;
        end
        return e;
    endfunction

    task automatic wait_valid(output int busy_cycles);
        int guard;
        busy_cycles = 0;
        guard       = 0;
        while (valid !== 1'b1 && guard < 4 * DIGITS + 8) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            guard++;
        end
        check("valid_within_bound", valid, 1);
    endtask

    task automatic compare_result();
        check("scoreboard_pending", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
            last_exp = sb_q.pop_front();
            check("result", result, last_exp.result);
            check("cout", cout, last_exp.cout);
            check("err", err, last_exp.err);
        end
    endtask

    // Called and returns at a falling edge; ends one cycle after the ack edge.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub, input int hold);
        int bc;
        check("ready_before_start", ready, 1);
        a     = ta;
        b     = tb;
        sub   = tsub;
        start = 1'b1;
        sb_q.push_back(model(ta, tb, tsub));
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        sub   = 1'($urandom);
        check("ready_low_in_run", ready, 0);
        wait_valid(bc);
        check("busy_cycles", bc, DIGITS);
        check("busy_low_in_done", busy, 0);
        repeat (hold) begin
            @(negedge clk);
            check("valid_held", valid, 1);
        end
        compare_result();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("valid_after_ack", valid, 0);
        check("ready_after_ack", ready, 1);
        check("result_kept_after_ack", result, last_exp.result);
    endtask

    initial begin
        int bc;
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        ack   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_ready", ready, 1);
        check("reset_busy", busy, 0);
        check("reset_valid", valid, 0);
        check("reset_result", result, 0);
        check("reset_cout", cout, 0);
        check("reset_err", err, 0);

        run_op(8'h45, 8'h38, 1'b0, 5);
        run_op(8'h99, 8'h01, 1'b0, 0);
        run_op(8'h00, 8'h00, 1'b0, 1);
        run_op(8'h45, 8'h38, 1'b1, 0);
        run_op(8'h38, 8'h45, 1'b1, 2);
        run_op(8'h50, 8'h50, 1'b1, 0);
        run_op(8'h4A, 8'h01, 1'b0, 1);
        run_op(8'h27, 8'hF0, 1'b1, 0);
        run_op(8'h99, 8'h99, 1'b0, 0);
        run_op(8'h00, 8'h01, 1'b1, 0);

        // start during RUN and start together with ack in DONE are ignored
        a     = 8'h11;
        b     = 8'h22;
        sub   = 1'b0;
        start = 1'b1;
        sb_q.push_back(model(8'h11, 8'h22, 1'b0));
        @(negedge clk);
        a = 8'h99;
        b = 8'h99;
        @(negedge clk);
        start = 1'b0;
        wait_valid(bc);
        compare_result();
        ack   = 1'b1;
        start = 1'b1;
        a     = 8'h55;
        b     = 8'h55;
        @(negedge clk);
        ack   = 1'b0;
        start = 1'b0;
        check("hs_valid_low", valid, 0);
        check("hs_ready_high", ready, 1);
        check("hs_not_busy", busy, 0);
        @(negedge clk);
        check("hs_still_idle", busy, 0);
        check("hs_no_second_result", valid, 0);

        // back-to-back: run_op issues start in the cycle right after ack
        run_op(8'h12, 8'h09, 1'b0, 0);
        run_op(8'h80, 8'h35, 1'b1, 0);

        // reset in the middle of RUN discards the operation
        a     = 8'h77;
        b     = 8'h66;
        sub   = 1'b0;
        start = 1'b1;
        sb_q.push_back(model(8'h77, 8'h66, 1'b0));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_reset_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb_q.pop_back());
        check("midrun_reset_ready", ready, 1);
        check("midrun_reset_busy", busy, 0);
        check("midrun_reset_valid", valid, 0);
        check("midrun_reset_result", result, 0);
        check("midrun_reset_cout", cout, 0);
        run_op(8'h12, 8'h34, 1'b0, 0);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_serial_alu.md
Name: bcd_serial_alu

Overview:
- Multi-digit packed-BCD add/subtract unit built around a single-digit BCD adder/subtractor slice (nine's-complement subtract, +6 correction).
- A controller sequences the slice over DIGITS digits, least-significant digit first, one digit per clock.
- Uses a start/ready request handshake and a valid/ack result handshake.
- Replaces the wide ripple chain of parallel digit slices wherever area beats latency.

Parameters:
- DIGITS, 4: number of BCD digits per operand; >=1.
- CW, 3: width of the digit counter; must satisfy 2^CW >= DIGITS.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when ready=1.
- sub  input  1  operation select: 0 = a+b, 1 = a-b; sampled with start.
- a  input  4*DIGITS  packed BCD operand, digit 0 in bits [3:0]; sampled with start.
- b  input  4*DIGITS  packed BCD operand, same packing; sampled with start.
- ready  output  1  idle, can accept start.
- busy  output  1  computation in progress.
- valid  output  1  result, cout and err are valid.
- ack  input  1  consumer takes the result; meaningful only while valid=1.
- result  output  4*DIGITS  packed BCD result.
- cout  output  1  final digit carry.
- err  output  1  at least one input digit was greater than 9.

Behaviour:
- Reset: state is IDLE. Outputs: ready=1, busy=0, valid=0, result=0, cout=0, err=0. The counter, operand registers and carry register are all cleared.
- Reset has priority over everything, including mid-RUN and DONE; any in-flight operation is discarded.
- FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - ready=1.
  - On start=1 at an edge: latch a, b and sub; set carry register = sub; set counter = 0; compute err; go to RUN.
  - ready is 0 from the next cycle on.
- RUN:
  - busy=1.
  - Each edge processes the current digit pair (opA[3:0], opB[3:0], carry): add mode adds b; sub mode adds the nine's complement of b.
  - The corrected sum digit is shifted in at the top of the result register (result shifts right 4).
  - The operand registers shift right 4.
  - The carry register takes the digit carry-out; the counter increments.
  - When the counter reaches DIGITS-1 at an edge, the last digit is processed and the state goes to DONE.
- Latency: with start accepted at edge E0, valid is first high after edge E(DIGITS), i.e. exactly DIGITS cycles of busy=1.
- DONE:
  - valid=1; result, cout and err are held stable until the edge with ack=1.
  - At that edge, go to IDLE with valid=0, ready=1.
  - result, cout and err keep their last values after ack (not cleared).
- start is ignored outside IDLE. This includes start together with ack in DONE; a new start is accepted no earlier than the cycle after ack.
- ack is ignored outside DONE.
- Arithmetic:
  - Subtraction is computed as a + (10^DIGITS-1-b) + 1, i.e. the result is modulo 10^DIGITS (ten's complement).
  - cout semantics:
    - In add mode, cout=1 means a+b >= 10^DIGITS; result = (a+b) mod 10^DIGITS.
    - In sub mode, cout=1 means a >= b (no borrow). cout=0 means a < b, and result is the ten's complement of b-a.
- Digit correction: let z = 5-bit binary sum of the digit pair plus carry. If z > 9, the digit is (z+6) mod 16 with carry-out 1; otherwise the digit is z with carry-out 0.
- err:
  - Set when any digit of a or b is greater than 9 at accept.
  - Latency is unchanged, but at DONE result is forced to 0 and cout to 0, with err=1.
- busy and ready are never both 1; valid is high only in DONE.

Test Plan:
- DIGITS=2, add: start with a=0x45, b=0x38, sub=0 -> busy for 2 cycles, then valid=1, result=0x83, cout=0, err=0; valid held while ack=0 for 5 cycles.
- DIGITS=2, add wrap: a=0x99, b=0x01 -> result=0x00, cout=1; a=0x00, b=0x00 -> result=0x00, cout=0.
- DIGITS=2, sub: a=0x45, b=0x38, sub=1 -> result=0x07, cout=1; a=0x38, b=0x45, sub=1 -> result=0x93, cout=0; a=b=0x50 -> result=0x00, cout=1.
- Invalid input: a=0x4A, b=0x01 -> after 2 cycles valid=1, err=1, result=0x00, cout=0.
- Handshake: start pulsed during RUN and in DONE together with ack -> ignored (no second result). Back-to-back: start in the cycle after ack -> accepted, second result correct.
- Reset: rst=1 in the middle of RUN -> next cycle ready=1, busy=0, valid=0, result=0. A following add 0x12+0x34 -> result 0x46.
